// File: rtl/ha_array_pkg.sv
// Shared constants and types for the half-adder row accumulator.
// Row i carries a 9-bit sum vector t and a 7-bit carry vector b.
package ha_array_pkg;

    localparam int ROWS      = 4;
    localparam int T_W       = 9;
    localparam int B_W       = 7;
    localparam int PROD_W    = 16;
    localparam int ROW_VAL_W = 10;
    localparam int ACC_W     = PROD_W + 1;
    localparam int ROW_IDX_W = $clog2(ROWS);

    typedef logic [B_W-1:0]       row_b_t;
    typedef logic [T_W-1:0]       row_t_t;
    typedef logic [ROW_VAL_W-1:0] row_val_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } acc_state_e;

endpackage

// File: rtl/ha_row_value.sv
// Combinational value of one row pair: the carry vector b sits two bits
// above the sum vector t, so row_val = t + (b << 2), at most 1019.
module ha_row_value
    import ha_array_pkg::*;
(
    input  logic [B_W-1:0]       b,
    input  logic [T_W-1:0]       t,
    output logic [ROW_VAL_W-1:0] row_val
);

    assign row_val = ROW_VAL_W'(t) + (ROW_VAL_W'(b) << 2);

endmodule

// File: rtl/ha_array_accumulator.sv
// Captures four half-adder row pairs and folds one weighted row per cycle
// into a 17-bit accumulator; bit 16 is reported as overflow.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is high only in IDLE (and never during reset), out_valid
// only in DONE; product/overflow are held until out_ready takes the result.
module ha_array_accumulator
    import ha_array_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [B_W-1:0]    ha_array_0_b,
    input  logic [B_W-1:0]    ha_array_1_b,
    input  logic [B_W-1:0]    ha_array_2_b,
    input  logic [B_W-1:0]    ha_array_3_b,
    input  logic [T_W-1:0]    ha_array_0_t,
    input  logic [T_W-1:0]    ha_array_1_t,
    input  logic [T_W-1:0]    ha_array_2_t,
    input  logic [T_W-1:0]    ha_array_3_t,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              overflow,
    output logic [1:0]        dbg_state_o
);

    acc_state_e           state_q, state_d;
    logic [ROW_IDX_W-1:0] row_idx_q, row_idx_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    row_b_t               b_q [ROWS];
    row_t_t               t_q [ROWS];

    row_val_t             row_val;
    logic [ACC_W-1:0]     addend;
    logic                 capture_en;

    ha_row_value u_row_value (
        .b       (b_q[row_idx_q]),
        .t       (t_q[row_idx_q]),
        .row_val (row_val)
    );

    // Row i lands at bit position 2*i.
    assign addend     = ACC_W'(row_val) << {row_idx_q, 1'b0};
    assign capture_en = (state_q == IDLE) && in_valid;

    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        acc_d     = acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d   = ACC;
                    row_idx_d = '0;
                    acc_d     = '0;
                end
            end
            ACC: begin
                acc_d     = acc_q + addend;
                row_idx_d = row_idx_q + 1'b1;
                if (row_idx_q == ROW_IDX_W'(ROWS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_idx_q <= '0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            acc_q     <= acc_d;
        end
    end

    // Row capture needs no reset: contents are only read after a fresh capture.
    always_ff @(posedge clk) begin
        if (rst_n && capture_en) begin
            b_q[0] <= ha_array_0_b;
            b_q[1] <= ha_array_1_b;
            b_q[2] <= ha_array_2_b;
            b_q[3] <= ha_array_3_b;
            t_q[0] <= ha_array_0_t;
            t_q[1] <= ha_array_1_t;
            t_q[2] <= ha_array_2_t;
            t_q[3] <= ha_array_3_t;
        end
    end

    assign in_ready    = rst_n && (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign product     = acc_q[PROD_W-1:0];
    assign overflow    = acc_q[ACC_W-1];
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ha_array_accumulator.sv
// Directed and random transactions for ha_array_accumulator, checked against
// a bit-weight model through an expected-result queue.
module tb_ha_array_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_b [4];
    logic [8:0]  in_t [4];
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        overflow;
    logic [1:0]  dbg_state;

    logic [16:0] exp_q[$];
    int          n_checks;
    int          n_pass;

    ha_array_accumulator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ha_array_0_b (in_b[0]),
        .ha_array_1_b (in_b[1]),
        .ha_array_2_b (in_b[2]),
        .ha_array_3_b (in_b[3]),
        .ha_array_0_t (in_t[0]),
        .ha_array_1_t (in_t[1]),
        .ha_array_2_t (in_t[2]),
        .ha_array_3_t (in_t[3]),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .overflow     (overflow),
        .dbg_state_o  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // t[k] of row i weighs 2^(2i+k); b[k] of row i weighs 2^(2i+k+2).
    function automatic logic [16:0] model_sum();
        int unsigned s;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 9; k++) if (in_t[i][k]) s += (32'd1 << (2*i + k));
            for (int k = 0; k < 7; k++) if (in_b[i][k]) s += (32'd1 << (2*i + k + 2));
        end
        return s[16:0];
    endfunction

    task automatic set_zero();
        for (int i = 0; i < 4; i++) begin
            in_b[i] = '0;
            in_t[i] = '0;
        end
    endtask

    task automatic set_random();
        for (int i = 0; i < 4; i++) begin
            in_b[i] = 7'($urandom_range(0, 127));
            in_t[i] = 9'($urandom_range(0, 511));
        end
    endtask

    // Offers the current vectors; returns at the negedge of the cycle after acceptance.
    task automatic send(input bit push);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("send_in_ready", in_ready, 1);
        in_valid = 1'b1;
        @(posedge clk);
        if (push) exp_q.push_back(model_sum());
        @(negedge clk);
        in_valid = 1'b0;
        set_random();
    endtask

    // Waits for out_valid (expected 5 cycles after acceptance), optionally stalls, then takes it.
    task automatic collect(input string tag, input int hold);
        int          lat;
        logic [16:0] exp;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 5);
        check({tag, "_in_ready_done"}, in_ready, 0);
        exp = '0;
        if (exp_q.size() == 0) check({tag, "_queue_nonempty"}, 0, 1);
        else exp = exp_q.pop_front();
        check({tag, "_product"}, product, exp[15:0]);
        check({tag, "_overflow"}, overflow, exp[16]);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_product"}, product, exp[15:0]);
            check({tag, "_hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle_valid"}, out_valid, 0);
        check({tag, "_idle_in_ready"}, in_ready, 1);
    endtask

    initial begin
        logic        seen;
        logic [16:0] exp;
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_zero();
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_product", product, 0);
        check("rst_overflow", overflow, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        set_zero(); in_t[0] = 9'h001;
        check("model_row0", model_sum(), 17'd1);
        send(1); collect("row0_t0", 0);

        set_zero(); in_t[3] = 9'h100;
        check("model_row3", model_sum(), 17'd16384);
        send(1); collect("row3_t8", 0);

        set_zero(); in_b[2] = 7'h40;
        check("model_row2b", model_sum(), 17'd4096);
        send(1); collect("row2_b6", 0);

        for (int i = 0; i < 4; i++) begin
            in_b[i] = 7'h7f;
            in_t[i] = 9'h1ff;
        end
        check("model_ones", model_sum(), 17'h15257);
        send(1); collect("all_ones", 0);

        set_zero();
        send(1); collect("zeros", 0);

        set_random();
        send(1); collect("stall10", 10);

        // Offer a new set in the very DONE cycle that releases the result.
        set_random();
        send(1);
        while (!out_valid) @(negedge clk);
        exp = exp_q.pop_front();
        check("overlap_a_product", product, exp[15:0]);
        set_random();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check("overlap_in_ready_done", in_ready, 0);
        @(negedge clk);
        out_ready = 1'b0;
        check("overlap_idle_valid", out_valid, 0);
        check("overlap_in_ready_idle", in_ready, 1);
        send(1); collect("overlap_b", 0);

        // Reset during the third cycle of a transaction.
        set_random();
        send(0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_product", product, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_state", dbg_state, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready_after", in_ready, 1);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_stale", seen, 0);

        for (int r = 0; r < 6; r++) begin
            set_random();
            send(1);
            collect("random", $urandom_range(0, 3));
        end

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
